// File: rtl/sonar_pkg.sv
// Shared constants for the sonar echo detector: register map, FSM states, CONTROL bits.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sonar_pkg;

    // Register addresses on the 16-bit management bus
    localparam logic [3:0] ADR_CONTROL   = 4'd0;
    localparam logic [3:0] ADR_STATUS    = 4'd1;
    localparam logic [3:0] ADR_THRESHOLD = 4'd2;
    localparam logic [3:0] ADR_HOLD      = 4'd3;
    localparam logic [3:0] ADR_TIMEOUT   = 4'd4;
    localparam logic [3:0] ADR_TIMER     = 4'd5;
    localparam logic [3:0] ADR_CH_MASK   = 4'd6;
    localparam logic [3:0] ADR_TOF0      = 4'd8;

    // CONTROL register bit positions
    localparam int CTL_EN      = 0;
    localparam int CTL_MAN     = 1;
    localparam int CTL_MAN_STB = 2;
    localparam int CTL_SW_CLR  = 3;

    // Ping-window state; encoding is visible in STATUS[1:0]
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

endpackage

// File: rtl/echo_channel.sv
// One detector channel: rectify, moving average, persistence count, first-echo TOF capture.
// Latency: det/tof update on the clock edge that samples stb; hit is the same-cycle detect.
// Backpressure: none; a sample is consumed on every stb, clr discards the concurrent sample.
module echo_channel
    import sonar_pkg::*;
#(
    parameter int DW       = 16,
    parameter int MAF_LOG2 = 3,
    parameter int TW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stb,
    input  logic          clr,
    input  logic          arm,
    input  logic [DW-1:0] pcm,
    input  logic [DW-1:0] threshold,
    input  logic [7:0]    hold,
    input  logic [TW-1:0] timer,
    output logic          hit,
    output logic          det,
    output logic [TW-1:0] tof
);

    localparam int DEPTH = 1 << MAF_LOG2;
    localparam int SW    = DW + MAF_LOG2;

    logic [DW-1:0] win [DEPTH];
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_nxt;
    logic [DW-1:0] mag;
    logic [DW-1:0] avg;
    logic [7:0]    run_q;
    logic [7:0]    run_nxt;
    logic [7:0]    hold_eff;

    // Rectify, update running sum and run count for the sample on the input now
    always_comb begin
        mag = pcm;
        if (pcm[DW-1]) begin
            // Most negative code has no positive twin; clamp to the largest positive value
            if (pcm == {1'b1, {(DW-1){1'b0}}})
                mag = {1'b0, {(DW-1){1'b1}}};
            else
                mag = -pcm;
        end
        sum_nxt  = sum_q + SW'(mag) - SW'(win[DEPTH-1]);
        avg      = sum_nxt[SW-1:MAF_LOG2];
        run_nxt  = (avg > threshold) ? ((run_q == 8'hFF) ? run_q : run_q + 8'd1) : 8'd0;
        hold_eff = (hold == 8'd0) ? 8'd1 : hold;
        hit      = stb & arm & ~clr & ~det & (run_nxt >= hold_eff);
    end

    // Window, sum, run count and first-echo capture; clear beats a concurrent strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum_q <= '0;
            run_q <= '0;
            det   <= 1'b0;
            tof   <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum_q <= '0;
            run_q <= '0;
            det   <= 1'b0;
            tof   <= '0;
        end else if (stb) begin
            win[0] <= mag;
            for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
            sum_q <= sum_nxt;
            run_q <= run_nxt;
            if (hit) begin
                det <= 1'b1;
                tof <= timer;
            end
        end
    end

endmodule

// File: rtl/sonar_echo_detect.sv
// Multi-channel sonar echo detector: register bank, strobe mux, ping timer/FSM, IRQ.
// Latency: cmp/state/irq one clock after stb; bus ack one clock after an accepted request.
// Backpressure: bus master sees ack every other cycle when holding valid; PCM is never stalled.
module sonar_echo_detect
    import sonar_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DW       = 16,
    parameter int MAF_LOG2 = 3,
    parameter int TW       = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wb_valid_i,
    input  logic [3:0]         wbs_adr_i,
    input  logic [15:0]        wbs_dat_i,
    input  logic               wbs_strb_i,
    output logic               wbs_ack_o,
    output logic [15:0]        wbs_dat_o,
    input  logic               ce_pcm,
    input  logic [N_CH*DW-1:0] pcm_i,
    input  logic               mclear,
    output logic [N_CH-1:0]    cmp_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic               irq_o
);

    logic            ctl_en;
    logic            ctl_man;
    logic            ctl_man_stb;
    logic            ctl_sw_clr;
    logic [DW-1:0]   thr_q;
    logic [7:0]      hold_q;
    logic [TW-1:0]   tmo_q;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_inc;
    logic [N_CH-1:0] mask_q;
    state_t          state_q;
    state_t          state_nxt;
    logic            irq_nxt;
    logic            all_det;

    logic [N_CH-1:0] arm;
    logic [N_CH-1:0] hit;
    logic [N_CH-1:0] det;
    logic [TW-1:0]   tof [N_CH];

    logic            stb;
    logic            clr;
    logic            acc;
    logic            wr;
    logic [15:0]     rd_dat;

    assign stb = ctl_man ? ctl_man_stb : ce_pcm;
    assign clr = (mclear | ctl_sw_clr) & ctl_en;
    // A request is taken only while ack is low, which gives the every-other-cycle cadence
    assign acc = wb_valid_i & ~wbs_ack_o;
    assign wr  = acc & wbs_strb_i;
    assign arm = {N_CH{ctl_en && (state_q == ST_RUN)}} & mask_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        echo_channel #(
            .DW       (DW),
            .MAF_LOG2 (MAF_LOG2),
            .TW       (TW)
        ) u_ch (
            .clk       (wb_clk_i),
            .rst_n     (wb_rst_ni),
            .stb       (stb),
            .clr       (clr),
            .arm       (arm[c]),
            .pcm       (pcm_i[c*DW +: DW]),
            .threshold (thr_q),
            .hold      (hold_q),
            .timer     (timer_q),
            .hit       (hit[c]),
            .det       (det[c]),
            .tof       (tof[c])
        );
    end

    assign cmp_o = det;

    // Register writes; sw_clr is a one-cycle pulse unless rewritten
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ctl_en      <= 1'b0;
            ctl_man     <= 1'b0;
            ctl_man_stb <= 1'b0;
            ctl_sw_clr  <= 1'b0;
            thr_q       <= '0;
            hold_q      <= '0;
            tmo_q       <= '0;
            mask_q      <= '1;
        end else begin
            ctl_sw_clr <= 1'b0;
            if (wr) begin
                case (wbs_adr_i)
                    ADR_CONTROL: begin
                        ctl_en      <= wbs_dat_i[CTL_EN];
                        ctl_man     <= wbs_dat_i[CTL_MAN];
                        ctl_man_stb <= wbs_dat_i[CTL_MAN_STB];
                        ctl_sw_clr  <= wbs_dat_i[CTL_SW_CLR];
                    end
                    ADR_THRESHOLD: thr_q  <= DW'(wbs_dat_i);
                    ADR_HOLD:      hold_q <= wbs_dat_i[7:0];
                    ADR_TIMEOUT:   tmo_q  <= TW'(wbs_dat_i);
                    ADR_CH_MASK:   mask_q <= N_CH'(wbs_dat_i);
                    default: ;
                endcase
            end
        end
    end

    // Read mux; unmapped addresses and unused bits read as zero
    always_comb begin
        rd_dat = '0;
        case (wbs_adr_i)
            ADR_CONTROL: begin
                rd_dat[CTL_EN]      = ctl_en;
                rd_dat[CTL_MAN]     = ctl_man;
                rd_dat[CTL_MAN_STB] = ctl_man_stb;
                rd_dat[CTL_SW_CLR]  = ctl_sw_clr;
            end
            ADR_STATUS:    rd_dat = {8'(det), 6'd0, state_q};
            ADR_THRESHOLD: rd_dat = 16'(thr_q);
            ADR_HOLD:      rd_dat = {8'd0, hold_q};
            ADR_TIMEOUT:   rd_dat = 16'(tmo_q);
            ADR_TIMER:     rd_dat = 16'(timer_q);
            ADR_CH_MASK:   rd_dat = 16'(mask_q);
            default:       rd_dat = '0;
        endcase
        for (int c = 0; c < N_CH; c++) begin
            if (wbs_adr_i == ADR_TOF0 + 4'(c)) rd_dat = 16'(tof[c]);
        end
    end

    // Bus response: data is captured before the write at the same edge takes effect
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= acc ? rd_dat : 16'd0;
        end
    end

    // Next-state logic; DONE is checked before TIMEOUT so a late last echo still wins
    always_comb begin
        timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        all_det   = (mask_q != '0) && ((mask_q & ~(det | hit)) == '0);
        state_nxt = state_q;
        irq_nxt   = 1'b0;
        if (!ctl_en) begin
            state_nxt = ST_IDLE;
        end else if (clr) begin
            state_nxt = ST_RUN;
        end else if ((state_q == ST_RUN) && stb) begin
            if (all_det) begin
                state_nxt = ST_DONE;
                irq_nxt   = 1'b1;
            end else if ((tmo_q != '0) && (timer_inc == tmo_q)) begin
                state_nxt = ST_TIMEOUT;
                irq_nxt   = 1'b1;
            end
        end
    end

    // State, timer and registered status outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            done_o    <= (state_nxt == ST_DONE);
            timeout_o <= (state_nxt == ST_TIMEOUT);
            irq_o     <= irq_nxt;
            if (!ctl_en || clr)
                timer_q <= '0;
            else if ((state_q == ST_RUN) && stb)
                timer_q <= timer_inc;
        end
    end

endmodule

// File: tb/tb_sonar_echo_detect.sv
// Self-checking bench for sonar_echo_detect against a queue-based behavioural model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bus accesses are single requests followed by an idle cycle.
module tb_sonar_echo_detect;

    localparam int N_CH  = 4;
    localparam int DW    = 16;
    localparam int MAF_LOG2 = 3;
    localparam int TW    = 16;
    localparam int DEPTH = 1 << MAF_LOG2;

    logic               wb_clk_i   = 1'b0;
    logic               wb_rst_ni  = 1'b0;
    logic               wb_valid_i = 1'b0;
    logic [3:0]         wbs_adr_i  = '0;
    logic [15:0]        wbs_dat_i  = '0;
    logic               wbs_strb_i = 1'b0;
    logic               wbs_ack_o;
    logic [15:0]        wbs_dat_o;
    logic               ce_pcm     = 1'b0;
    logic [N_CH*DW-1:0] pcm_i      = '0;
    logic               mclear     = 1'b0;
    logic [N_CH-1:0]    cmp_o;
    logic               done_o;
    logic               timeout_o;
    logic               irq_o;

    always #5 wb_clk_i = ~wb_clk_i;

    sonar_echo_detect #(.N_CH(N_CH), .DW(DW), .MAF_LOG2(MAF_LOG2), .TW(TW)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .wb_valid_i (wb_valid_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_strb_i (wbs_strb_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .ce_pcm     (ce_pcm),
        .pcm_i      (pcm_i),
        .mclear     (mclear),
        .cmp_o      (cmp_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .irq_o      (irq_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: sample history per channel, plain integer arithmetic
    int m_thr, m_hold, m_tmo, m_mask;
    int m_hist [N_CH][$];
    int m_run  [N_CH];
    bit m_det  [N_CH];
    int m_tof  [N_CH];
    int m_timer;
    int m_state;   // 0 idle, 1 run, 2 done, 3 timeout
    bit m_irq;

    function automatic int mag(input int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    task automatic m_clear();
        for (int c = 0; c < N_CH; c++) begin
            m_hist[c].delete();
            m_run[c] = 0;
            m_det[c] = 1'b0;
            m_tof[c] = 0;
        end
        m_timer = 0;
        m_state = 1;
        m_irq   = 1'b0;
    endtask

    task automatic m_strobe(input int x[N_CH]);
        int hold_eff;
        int sum;
        bit all;
        hold_eff = (m_hold == 0) ? 1 : m_hold;
        m_irq = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            m_hist[c].push_front(mag(x[c]));
            if (m_hist[c].size() > DEPTH) void'(m_hist[c].pop_back());
            sum = 0;
            foreach (m_hist[c][i]) sum += m_hist[c][i];
            if (sum / DEPTH > m_thr) m_run[c] = (m_run[c] < 255) ? m_run[c] + 1 : 255;
            else m_run[c] = 0;
            if (m_state == 1 && m_mask[c] && !m_det[c] && m_run[c] >= hold_eff) begin
                m_det[c] = 1'b1;
                m_tof[c] = m_timer;
            end
        end
        if (m_state == 1) begin
            if (m_timer < 65535) m_timer++;
            all = (m_mask != 0);
            for (int c = 0; c < N_CH; c++) if (m_mask[c] && !m_det[c]) all = 1'b0;
            if (all) begin
                m_state = 2;
                m_irq = 1'b1;
            end else if (m_tmo != 0 && m_timer == m_tmo) begin
                m_state = 3;
                m_irq = 1'b1;
            end
        end
    endtask

    function automatic logic [N_CH+2:0] m_out();
        logic [N_CH-1:0] d;
        for (int c = 0; c < N_CH; c++) d[c] = m_det[c];
        return {d, m_state == 2, m_state == 3, m_irq};
    endfunction

    function automatic logic [15:0] m_status();
        logic [N_CH-1:0] d;
        for (int c = 0; c < N_CH; c++) d[c] = m_det[c];
        return {8'(d), 6'd0, 2'(m_state)};
    endfunction

    // Stimulus primitives
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic bus(input logic [3:0] adr, input logic we, input logic [15:0] wd,
                       output logic [15:0] rd);
        wb_valid_i = 1'b1;
        wbs_adr_i  = adr;
        wbs_strb_i = we;
        wbs_dat_i  = wd;
        tick();
        rd = wbs_dat_o;
        wb_valid_i = 1'b0;
        wbs_strb_i = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [3:0] adr, input logic [15:0] wd);
        logic [15:0] dummy;
        bus(adr, 1'b1, wd, dummy);
    endtask

    task automatic rd(input logic [3:0] adr, output logic [15:0] v);
        bus(adr, 1'b0, 16'd0, v);
    endtask

    task automatic cfg(input int thr, input int hold, input int tmo, input int mask);
        m_thr = thr; m_hold = hold; m_tmo = tmo; m_mask = mask;
        wr(4'd2, 16'(thr));
        wr(4'd3, 16'(hold));
        wr(4'd4, 16'(tmo));
        wr(4'd6, 16'(mask));
        wr(4'd0, 16'h0001);
    endtask

    task automatic do_clear();
        mclear = 1'b1;
        tick();
        mclear = 1'b0;
        m_clear();
    endtask

    task automatic strobe(input int x[N_CH]);
        for (int c = 0; c < N_CH; c++) pcm_i[c*DW +: DW] = DW'(x[c]);
        ce_pcm = 1'b1;
        tick();
        ce_pcm = 1'b0;
        m_strobe(x);
    endtask

    // Scenarios
    task automatic test_reset();
        logic [15:0] v;
        logic e;
        wb_rst_ni = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({cmp_o, done_o, timeout_o, irq_o, wbs_ack_o, wbs_dat_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0",
                     {cmp_o, done_o, timeout_o, irq_o, wbs_ack_o, wbs_dat_o});
        end
        wb_rst_ni = 1'b1;
        tick();
        wb_valid_i = 1'b1;
        wbs_adr_i  = 4'd6;
        wbs_strb_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = (i % 2 == 0);
            n_vec++;
            if (wbs_ack_o !== e) begin
                n_err++;
                $display("FAIL ack_cadence cycle %0d: got %b required %b", i, wbs_ack_o, e);
            end
        end
        wb_valid_i = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            n_vec++;
            if (v !== ((a == 6) ? 16'h000F : 16'h0000)) begin
                n_err++;
                $display("FAIL reset_reg[%0d]: got %h required %h", a, v,
                         (a == 6) ? 16'h000F : 16'h0000);
            end
        end
        bus(4'd2, 1'b1, 16'h1234, v);
        n_vec++;
        if (v !== 16'h0000) begin
            n_err++;
            $display("FAIL prewrite_read: got %h required 0000", v);
        end
        rd(4'd2, v);
        n_vec++;
        if (v !== 16'h1234) begin
            n_err++;
            $display("FAIL write_readback: got %h required 1234", v);
        end
    endtask

    task automatic test_basic_detect();
        int x[N_CH];
        logic [15:0] v;
        cfg(100, 3, 0, 1);
        do_clear();
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < N_CH; c++) x[c] = 0;
            x[0] = 200;
            strobe(x);
            n_vec++;
            if ({cmp_o, done_o, timeout_o, irq_o} !== m_out()) begin
                n_err++;
                $display("FAIL basic_out s=%0d: got %b required %b", s,
                         {cmp_o, done_o, timeout_o, irq_o}, m_out());
            end
            n_vec++;
            if (cmp_o[0] !== (s >= 6)) begin
                n_err++;
                $display("FAIL basic_cmp0 s=%0d: got %b required %b", s, cmp_o[0], s >= 6);
            end
        end
        rd(4'd8, v);
        n_vec++;
        if (v !== 16'd6) begin
            n_err++;
            $display("FAIL basic_tof0: got %0d required 6", v);
        end
        rd(4'd1, v);
        n_vec++;
        if (v !== 16'h0102) begin
            n_err++;
            $display("FAIL basic_status: got %h required 0102", v);
        end
    endtask

    task automatic test_saturate();
        int x[N_CH];
        logic [15:0] v;
        cfg(32766, 1, 0, 2);
        do_clear();
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < N_CH; c++) x[c] = 0;
            x[1] = -32768;
            strobe(x);
            n_vec++;
            if (cmp_o[1] !== (s >= 7) || {cmp_o, done_o, timeout_o, irq_o} !== m_out()) begin
                n_err++;
                $display("FAIL sat_detect s=%0d: got %b required %b", s,
                         {cmp_o, done_o, timeout_o, irq_o}, m_out());
            end
        end
        rd(4'd9, v);
        n_vec++;
        if (v !== 16'd7) begin
            n_err++;
            $display("FAIL sat_tof1: got %0d required 7", v);
        end
        // Average must settle at exactly 32767, which does not exceed this threshold
        cfg(32767, 1, 0, 2);
        do_clear();
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < N_CH; c++) x[c] = 0;
            x[1] = -32768;
            strobe(x);
        end
        n_vec++;
        if (cmp_o !== 4'b0000 || {cmp_o, done_o, timeout_o, irq_o} !== m_out()) begin
            n_err++;
            $display("FAIL sat_ceiling: got %b required %b",
                     {cmp_o, done_o, timeout_o, irq_o}, m_out());
        end
    endtask

    task automatic test_timeout();
        int x[N_CH];
        logic [15:0] v;
        cfg(100, 3, 20, 3);
        do_clear();
        for (int s = 0; s < 24; s++) begin
            for (int c = 0; c < N_CH; c++) x[c] = 0;
            x[0] = 200;
            strobe(x);
            n_vec++;
            if ({cmp_o, done_o, timeout_o, irq_o} !== m_out()) begin
                n_err++;
                $display("FAIL tmo_out s=%0d: got %b required %b", s,
                         {cmp_o, done_o, timeout_o, irq_o}, m_out());
            end
            n_vec++;
            if (timeout_o !== (s >= 19) || irq_o !== (s == 19)) begin
                n_err++;
                $display("FAIL tmo_flags s=%0d: got to=%b irq=%b required to=%b irq=%b",
                         s, timeout_o, irq_o, s >= 19, s == 19);
            end
        end
        rd(4'd5, v);
        n_vec++;
        if (v !== 16'd20) begin
            n_err++;
            $display("FAIL tmo_timer: got %0d required 20", v);
        end
        rd(4'd9, v);
        n_vec++;
        if (v !== 16'd0) begin
            n_err++;
            $display("FAIL tmo_tof1: got %0d required 0", v);
        end
        rd(4'd1, v);
        n_vec++;
        if (v !== 16'h0103) begin
            n_err++;
            $display("FAIL tmo_status: got %h required 0103", v);
        end
    endtask

    task automatic test_done_wins();
        int x[N_CH];
        logic [15:0] v;
        cfg(100, 1, 10, 1);
        do_clear();
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < N_CH; c++) x[c] = 0;
            x[0] = (s == 9) ? 1000 : 0;
            strobe(x);
            n_vec++;
            if ({cmp_o, done_o, timeout_o, irq_o} !== m_out()) begin
                n_err++;
                $display("FAIL race_out s=%0d: got %b required %b", s,
                         {cmp_o, done_o, timeout_o, irq_o}, m_out());
            end
        end
        n_vec++;
        if ({done_o, timeout_o, irq_o} !== 3'b101) begin
            n_err++;
            $display("FAIL race_done_wins: got %b required 101", {done_o, timeout_o, irq_o});
        end
        rd(4'd5, v);
        n_vec++;
        if (v !== 16'd10) begin
            n_err++;
            $display("FAIL race_timer: got %0d required 10", v);
        end
    endtask

    task automatic test_manual_and_clear();
        int x[N_CH];
        int z[N_CH];
        logic [15:0] v;
        for (int c = 0; c < N_CH; c++) z[c] = 0;
        cfg(100, 1, 0, 1);
        pcm_i  = '0;
        ce_pcm = 1'b1;
        wr(4'd0, 16'h000B);
        m_clear();
        for (int k = 1; k <= 3; k++) begin
            wr(4'd0, 16'h0007);
            wr(4'd0, 16'h0003);
            m_strobe(z);
            m_strobe(z);
            rd(4'd5, v);
            n_vec++;
            if (v !== 16'(2 * k) || v !== 16'(m_timer)) begin
                n_err++;
                $display("FAIL manual_timer k=%0d: got %0d required %0d", k, v, 2 * k);
            end
        end
        ce_pcm = 1'b0;
        wr(4'd0, 16'h0001);
        do_clear();
        strobe(z);
        strobe(z);
        for (int c = 0; c < N_CH; c++) x[c] = 0;
        x[0] = 1000;
        strobe(x);
        n_vec++;
        if ({cmp_o, done_o, timeout_o, irq_o} !== m_out()) begin
            n_err++;
            $display("FAIL clr_pre: got %b required %b", {cmp_o, done_o, timeout_o, irq_o}, m_out());
        end
        rd(4'd8, v);
        n_vec++;
        if (v !== 16'd2) begin
            n_err++;
            $display("FAIL clr_pre_tof0: got %0d required 2", v);
        end
        do_clear();
        n_vec++;
        if ({cmp_o, done_o, timeout_o} !== 6'b0) begin
            n_err++;
            $display("FAIL clr_flags: got %b required 0", {cmp_o, done_o, timeout_o});
        end
        rd(4'd8, v);
        n_vec++;
        if (v !== 16'd0) begin
            n_err++;
            $display("FAIL clr_tof0: got %0d required 0", v);
        end
        rd(4'd1, v);
        n_vec++;
        if (v !== 16'h0001) begin
            n_err++;
            $display("FAIL clr_status: got %h required 0001", v);
        end
        strobe(z);
        strobe(z);
        strobe(z);
        rd(4'd5, v);
        n_vec++;
        if (v !== 16'd3) begin
            n_err++;
            $display("FAIL clr_timer_restart: got %0d required 3", v);
        end
        strobe(x);
        #2;
        wb_rst_ni = 1'b0;
        #1;
        n_vec++;
        if ({cmp_o, done_o, timeout_o, irq_o, wbs_ack_o, wbs_dat_o} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %h required 0",
                     {cmp_o, done_o, timeout_o, irq_o, wbs_ack_o, wbs_dat_o});
        end
        #2;
        wb_rst_ni = 1'b1;
        tick();
        rd(4'd6, v);
        n_vec++;
        if (v !== 16'h000F) begin
            n_err++;
            $display("FAIL async_reset_mask: got %h required 000f", v);
        end
        rd(4'd1, v);
        n_vec++;
        if (v !== 16'h0000) begin
            n_err++;
            $display("FAIL async_reset_status: got %h required 0000", v);
        end
    endtask

    task automatic test_random();
        int x[N_CH];
        int amp[N_CH];
        logic [15:0] v;
        for (int p = 0; p < 6; p++) begin
            cfg($urandom_range(50, 3000), $urandom_range(0, 4),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 40), $urandom_range(0, 15));
            for (int c = 0; c < N_CH; c++) amp[c] = $urandom_range(0, 4000);
            do_clear();
            for (int s = 0; s < 40; s++) begin
                for (int c = 0; c < N_CH; c++) begin
                    x[c] = int'($urandom_range(0, amp[c]));
                    if ($urandom_range(0, 1) == 1) x[c] = -x[c];
                    if ($urandom_range(0, 30) == 0) x[c] = -32768;
                end
                strobe(x);
                n_vec++;
                if ({cmp_o, done_o, timeout_o, irq_o} !== m_out()) begin
                    n_err++;
                    $display("FAIL rand_out p=%0d s=%0d: got %b required %b", p, s,
                             {cmp_o, done_o, timeout_o, irq_o}, m_out());
                end
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                    m_irq = 1'b0;
                    n_vec++;
                    if ({cmp_o, done_o, timeout_o, irq_o} !== m_out()) begin
                        n_err++;
                        $display("FAIL rand_gap p=%0d s=%0d: got %b required %b", p, s,
                                 {cmp_o, done_o, timeout_o, irq_o}, m_out());
                    end
                end
            end
            rd(4'd5, v);
            n_vec++;
            if (v !== 16'(m_timer)) begin
                n_err++;
                $display("FAIL rand_timer p=%0d: got %0d required %0d", p, v, m_timer);
            end
            rd(4'd1, v);
            n_vec++;
            if (v !== m_status()) begin
                n_err++;
                $display("FAIL rand_status p=%0d: got %h required %h", p, v, m_status());
            end
            for (int c = 0; c < N_CH; c++) begin
                rd(4'(8 + c), v);
                n_vec++;
                if (v !== 16'(m_tof[c])) begin
                    n_err++;
                    $display("FAIL rand_tof%0d p=%0d: got %0d required %0d", c, p, v, m_tof[c]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_detect();
        test_saturate();
        test_timeout();
        test_done_wins();
        test_manual_and_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
